// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one slow line-wide memory port between an I-cache and a
//            D-cache. One transaction at a time, each costing memory latency
//            plus a grant cycle and a release cycle.
//            ARB_MODE 0: D side wins ties, but I is forced in after
//            MAX_D_BURST consecutive D grants made while I was waiting.
//            ARB_MODE 1: ties alternate, starting with D after reset.
// Ports    : clk, rst_n (synchronous, active-low)
//            i_mem_* / d_mem_* : client request, address, write line, read
//                                line and completion pulse
//            mem_*             : shared slow memory request / response
//            i_grant_cnt, d_grant_cnt : saturating per-side grant counts
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ARB_MODE    = 0,
  parameter int MAX_D_BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_mem_read,
  input  logic         i_mem_write,
  input  logic [27:0]  i_mem_addr,
  input  logic [127:0] i_mem_wdata,
  output logic [127:0] i_mem_rdata,
  output logic         i_mem_ready,
  input  logic         d_mem_read,
  input  logic         d_mem_write,
  input  logic [27:0]  d_mem_addr,
  input  logic [127:0] d_mem_wdata,
  output logic [127:0] d_mem_rdata,
  output logic         d_mem_ready,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic [15:0]  i_grant_cnt,
  output logic [15:0]  d_grant_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I   = 2'd1,
    GNT_D   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] c_max_burst   = 4'(MAX_D_BURST);
  localparam logic       c_round_robin = (ARB_MODE != 0);

  state_t       r_state;
  state_t       w_next;
  logic [3:0]   r_burst_cnt;
  logic         r_last_d;
  logic         r_mem_read;
  logic         r_mem_write;
  logic [15:0]  r_i_grant_cnt;
  logic [15:0]  r_d_grant_cnt;

  logic         w_i_pend;
  logic         w_d_pend;
  logic         w_pick_i;
  logic         w_grant_i;
  logic         w_grant_d;
  logic         w_gnt_i_active;
  logic         w_gnt_d_active;

  assign w_i_pend = i_mem_read | i_mem_write;
  assign w_d_pend = d_mem_read | d_mem_write;

  // Next state and grant decision; grants are only ever made from IDLE.
  always_comb begin
    w_next    = r_state;
    w_pick_i  = 1'b0;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_i_pend && w_d_pend) begin
          if (c_round_robin) w_pick_i = r_last_d;
          else               w_pick_i = (r_burst_cnt == c_max_burst);
          w_grant_i = w_pick_i;
          w_grant_d = ~w_pick_i;
        end else begin
          w_grant_i = w_i_pend;
          w_grant_d = w_d_pend;
        end
        if (w_grant_i)      w_next = GNT_I;
        else if (w_grant_d) w_next = GNT_D;
      end
      GNT_I, GNT_D: begin
        if (mem_ready) w_next = RELEASE;
      end
      RELEASE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_burst_cnt   <= 4'd0;
      r_last_d      <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_i_grant_cnt <= 16'd0;
      r_d_grant_cnt <= 16'd0;
    end else begin
      r_state <= w_next;
      if (w_grant_i) begin
        // A combined read+write request is treated as a write.
        r_mem_write <= i_mem_write;
        r_mem_read  <= i_mem_read & ~i_mem_write;
        r_burst_cnt <= 4'd0;
        r_last_d    <= 1'b0;
        if (r_i_grant_cnt != 16'hFFFF) r_i_grant_cnt <= r_i_grant_cnt + 16'd1;
      end else if (w_grant_d) begin
        r_mem_write <= d_mem_write;
        r_mem_read  <= d_mem_read & ~d_mem_write;
        // Only D grants that overtake a waiting I count towards the burst.
        r_burst_cnt <= w_i_pend ? r_burst_cnt + 4'd1 : 4'd0;
        r_last_d    <= 1'b1;
        if (r_d_grant_cnt != 16'hFFFF) r_d_grant_cnt <= r_d_grant_cnt + 16'd1;
      end else if ((r_state == GNT_I || r_state == GNT_D) && mem_ready) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
      end
    end
  end

  // Gating with rst_n keeps the combinational outputs quiet during reset,
  // so an abandoned transaction never forwards a ready.
  assign w_gnt_i_active = rst_n && (r_state == GNT_I);
  assign w_gnt_d_active = rst_n && (r_state == GNT_D);

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_addr    = w_gnt_i_active ? i_mem_addr  :
                       w_gnt_d_active ? d_mem_addr  : 28'd0;
  assign mem_wdata   = w_gnt_i_active ? i_mem_wdata :
                       w_gnt_d_active ? d_mem_wdata : 128'd0;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;
  assign i_mem_ready = mem_ready & w_gnt_i_active;
  assign d_mem_ready = mem_ready & w_gnt_d_active;
  assign i_grant_cnt = r_i_grant_cnt;
  assign d_grant_cnt = r_d_grant_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. Instance 0 runs fixed
//            priority (ARB_MODE 0), instance 1 runs round-robin. Each has
//            its own clients, memory responder and transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int c_max_burst = 4;

  logic clk;
  logic rst_n;

  logic         i_rd [2], i_wr [2], d_rd [2], d_wr [2];
  logic [27:0]  i_ad [2], d_ad [2];
  logic [127:0] i_wd [2], d_wd [2], m_rdata [2];
  logic         m_ready [2];
  logic [127:0] i_rdo [2], d_rdo [2], m_wd [2];
  logic         i_rdy [2], d_rdy [2], m_rd [2], m_wr [2];
  logic [27:0]  m_ad [2];
  logic [15:0]  i_gc [2], d_gc [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_arbiter #(.ARB_MODE(k), .MAX_D_BURST(c_max_burst)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_mem_read(i_rd[k]), .i_mem_write(i_wr[k]), .i_mem_addr(i_ad[k]),
      .i_mem_wdata(i_wd[k]), .i_mem_rdata(i_rdo[k]), .i_mem_ready(i_rdy[k]),
      .d_mem_read(d_rd[k]), .d_mem_write(d_wr[k]), .d_mem_addr(d_ad[k]),
      .d_mem_wdata(d_wd[k]), .d_mem_rdata(d_rdo[k]), .d_mem_ready(d_rdy[k]),
      .mem_read(m_rd[k]), .mem_write(m_wr[k]), .mem_addr(m_ad[k]),
      .mem_wdata(m_wd[k]), .mem_rdata(m_rdata[k]), .mem_ready(m_ready[k]),
      .i_grant_cnt(i_gc[k]), .d_grant_cnt(d_gc[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Client state, indexed [instance][side]; side 0 = I, 1 = D.
  bit           c_act [2][2], c_rd [2][2], c_wr [2][2], c_persist [2][2];
  logic [27:0]  c_addr [2][2];
  logic [127:0] c_wdata [2][2];

  // Reference model: owner 0 = nobody, 1 = I, 2 = D.
  int own [2], burst [2], gcyc [2], lat [2], cnt_i [2], cnt_d [2];
  bit rel [2], last_d [2], mrd [2], mwr [2];

  // Bench configuration.
  bit rand_en, spur_en, lat_rand, force_rdy;
  int lat_cfg;

  // Observations taken from the DUT.
  int cyc, on [2], olog [2][16], ocyc [2][16], n_irdy [2], n_drdy [2];
  int rise [2], snap_i [2], snap_d [2];
  int prev_i [2], prev_d [2];
  bit wr_seen [2];

  int n_checks, n_errors;

  int exp_seq [2][6] = '{'{2, 2, 2, 2, 1, 2}, '{2, 1, 2, 1, 2, 1}};

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic client_random(input int k);
    logic [1:0] rw;
    for (int s = 0; s < 2; s++) begin
      if (!c_act[k][s]) begin
        if ($urandom_range(0, 2) == 0) begin
          rw             = 2'($urandom_range(1, 3));
          c_act[k][s]    = 1'b1;
          c_rd[k][s]     = rw[0];
          c_wr[k][s]     = rw[1];
          c_persist[k][s] = 1'b0;
          c_addr[k][s]   = 28'($urandom);
          c_wdata[k][s]  = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if (own[k] != s + 1 && $urandom_range(0, 9) == 0) begin
        c_act[k][s] = 1'b0;
      end
    end
  endtask

  task automatic drive_phase();
    for (int k = 0; k < 2; k++) begin
      if (rand_en) client_random(k);
      i_rd[k] = c_act[k][0] && c_rd[k][0];
      i_wr[k] = c_act[k][0] && c_wr[k][0];
      d_rd[k] = c_act[k][1] && c_rd[k][1];
      d_wr[k] = c_act[k][1] && c_wr[k][1];
      i_ad[k] = c_addr[k][0];
      d_ad[k] = c_addr[k][1];
      i_wd[k] = c_wdata[k][0];
      d_wd[k] = c_wdata[k][1];
      if (own[k] != 0) begin
        gcyc[k]++;
        m_ready[k] = (gcyc[k] == lat[k]);
      end else begin
        m_ready[k] = spur_en && ($urandom_range(0, 5) == 0);
      end
      if (force_rdy) m_ready[k] = 1'b1;
      m_rdata[k] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic check_phase();
    logic [27:0]  e_ad;
    logic [127:0] e_wd;
    for (int k = 0; k < 2; k++) begin
      e_ad = 28'd0;
      e_wd = 128'd0;
      if (rst_n && own[k] == 1) begin e_ad = i_ad[k]; e_wd = i_wd[k]; end
      if (rst_n && own[k] == 2) begin e_ad = d_ad[k]; e_wd = d_wd[k]; end
      check_val($sformatf("m%0d.mem_read", k),    m_rd[k], mrd[k]);
      check_val($sformatf("m%0d.mem_write", k),   m_wr[k], mwr[k]);
      check_val($sformatf("m%0d.mem_addr", k),    m_ad[k], e_ad);
      check_val($sformatf("m%0d.mem_wdata", k),   m_wd[k], e_wd);
      check_val($sformatf("m%0d.i_ready", k),     i_rdy[k], rst_n && m_ready[k] && own[k] == 1);
      check_val($sformatf("m%0d.d_ready", k),     d_rdy[k], rst_n && m_ready[k] && own[k] == 2);
      check_val($sformatf("m%0d.i_rdata", k),     i_rdo[k], m_rdata[k]);
      check_val($sformatf("m%0d.d_rdata", k),     d_rdo[k], m_rdata[k]);
      check_val($sformatf("m%0d.i_grant_cnt", k), i_gc[k], cnt_i[k]);
      check_val($sformatf("m%0d.d_grant_cnt", k), d_gc[k], cnt_d[k]);
      // Grant order as seen on the DUT's own counters.
      if (int'(i_gc[k]) > prev_i[k] && on[k] < 16) begin olog[k][on[k]] = 1; ocyc[k][on[k]] = cyc; on[k]++; end
      if (int'(d_gc[k]) > prev_d[k] && on[k] < 16) begin olog[k][on[k]] = 2; ocyc[k][on[k]] = cyc; on[k]++; end
      if (on[k] == 4 && snap_i[k] < 0) begin snap_i[k] = int'(i_gc[k]); snap_d[k] = int'(d_gc[k]); end
      prev_i[k] = int'(i_gc[k]);
      prev_d[k] = int'(d_gc[k]);
      n_irdy[k] += int'(i_rdy[k]);
      n_drdy[k] += int'(d_rdy[k]);
      if (m_rd[k] === 1'b1 && rise[k] < 0) rise[k] = cyc;
      if (m_wr[k] === 1'b1 && m_rd[k] === 1'b0 && m_wd[k] === {16{8'hA5}}) wr_seen[k] = 1'b1;
    end
  endtask

  task automatic grant(input int k, input int w, input bit ip);
    own[k]  = w;
    gcyc[k] = 0;
    lat[k]  = lat_rand ? int'($urandom_range(1, 6)) : lat_cfg;
    if (w == 1) begin
      mwr[k] = i_wr[k]; mrd[k] = i_rd[k] & ~i_wr[k];
      if (cnt_i[k] < 65535) cnt_i[k]++;
      burst[k] = 0; last_d[k] = 1'b0;
    end else begin
      mwr[k] = d_wr[k]; mrd[k] = d_rd[k] & ~d_wr[k];
      if (cnt_d[k] < 65535) cnt_d[k]++;
      burst[k] = ip ? burst[k] + 1 : 0; last_d[k] = 1'b1;
    end
  endtask

  task automatic model_step();
    bit ip, dp;
    int w;
    for (int k = 0; k < 2; k++) begin
      ip = i_rd[k] | i_wr[k];
      dp = d_rd[k] | d_wr[k];
      if (rst_n && m_ready[k] && own[k] == 1 && !c_persist[k][0]) c_act[k][0] = 1'b0;
      if (rst_n && m_ready[k] && own[k] == 2 && !c_persist[k][1]) c_act[k][1] = 1'b0;
      if (!rst_n) begin
        own[k] = 0; rel[k] = 1'b0; burst[k] = 0; last_d[k] = 1'b0;
        cnt_i[k] = 0; cnt_d[k] = 0; mrd[k] = 1'b0; mwr[k] = 1'b0;
      end else if (own[k] != 0) begin
        if (m_ready[k]) begin own[k] = 0; rel[k] = 1'b1; mrd[k] = 1'b0; mwr[k] = 1'b0; end
      end else if (rel[k]) begin
        rel[k] = 1'b0;
      end else if (ip || dp) begin
        if (ip && dp) begin
          if (k == 0) w = (burst[k] == c_max_burst) ? 1 : 2;
          else        w = last_d[k] ? 1 : 2;
        end else begin
          w = ip ? 1 : 2;
        end
        grant(k, w, ip);
      end
    end
  endtask

  task automatic tick();
    drive_phase();
    #1;
    check_phase();
    model_step();
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_obs();
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      on[k] = 0; n_irdy[k] = 0; n_drdy[k] = 0; rise[k] = -1;
      snap_i[k] = -1; snap_d[k] = -1; wr_seen[k] = 1'b0;
      prev_i[k] = int'(i_gc[k]); prev_d[k] = int'(d_gc[k]);
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 2; s++) begin c_act[k][s] = 1'b0; c_persist[k][s] = 1'b0; end
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic set_client(input int s, input bit rd, input bit wr, input logic [27:0] a,
                            input logic [127:0] wd, input bit persist);
    for (int k = 0; k < 2; k++) begin
      c_act[k][s] = 1'b1; c_rd[k][s] = rd; c_wr[k][s] = wr;
      c_addr[k][s] = a; c_wdata[k][s] = wd; c_persist[k][s] = persist;
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rand_en = 1'b0; spur_en = 1'b0; lat_rand = 1'b0; force_rdy = 1'b0; lat_cfg = 5;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_rd[k] = 0; i_wr[k] = 0; d_rd[k] = 0; d_wr[k] = 0; i_ad[k] = 0; d_ad[k] = 0;
      i_wd[k] = 0; d_wd[k] = 0; m_rdata[k] = 0; m_ready[k] = 0;
      for (int s = 0; s < 2; s++) begin c_addr[k][s] = 0; c_wdata[k][s] = 0; end
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    do_reset();

    // Single I read, latency 5.
    lat_cfg = 5;
    set_client(0, 1'b1, 1'b0, 28'h0000010, 128'd0, 1'b0);
    for (int t = 0; t < 12; t++) tick();
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("m%0d.single_i_gcnt", k), i_gc[k], 1);
      check_val($sformatf("m%0d.single_i_pulses", k), n_irdy[k], 1);
      check_val($sformatf("m%0d.single_i_rise", k), rise[k], 1);
    end

    // Simultaneous I and D: D first, I right after release.
    do_reset();
    lat_cfg = 3;
    set_client(0, 1'b1, 1'b0, 28'h0000020, 128'd0, 1'b0);
    set_client(1, 1'b1, 1'b0, 28'h0000030, 128'd0, 1'b0);
    for (int t = 0; t < 16; t++) tick();
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("m%0d.tie_grants", k), on[k], 2);
      check_val($sformatf("m%0d.tie_first", k), olog[k][0], 2);
      check_val($sformatf("m%0d.tie_second", k), olog[k][1], 1);
      check_val($sformatf("m%0d.tie_gap", k), ocyc[k][1] - ocyc[k][0], lat_cfg + 2);
    end

    // Both sides continuously pending.
    do_reset();
    lat_cfg = 2;
    set_client(0, 1'b1, 1'b0, 28'h0000040, 128'd0, 1'b1);
    set_client(1, 1'b1, 1'b0, 28'h0000050, 128'd0, 1'b1);
    for (int t = 0; t < 100 && (on[0] < 6 || on[1] < 6); t++) tick();
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("m%0d.cont_grants", k), on[k] >= 6, 1'b1);
      for (int j = 0; j < 6; j++)
        check_val($sformatf("m%0d.cont_order%0d", k, j), olog[k][j], exp_seq[k][j]);
    end
    check_val("m1.rr_snap_i", snap_i[1], 2);
    check_val("m1.rr_snap_d", snap_d[1], 2);
    check_val("m0.fx_snap_d", snap_d[0], 4);

    // D write.
    do_reset();
    lat_cfg = 4;
    spur_en = 1'b1;
    set_client(1, 1'b0, 1'b1, 28'h0000100, {16{8'hA5}}, 1'b0);
    for (int t = 0; t < 10; t++) tick();
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("m%0d.dwr_seen", k), wr_seen[k], 1'b1);
      check_val($sformatf("m%0d.dwr_dpulses", k), n_drdy[k], 1);
      check_val($sformatf("m%0d.dwr_ipulses", k), n_irdy[k], 0);
    end
    spur_en = 1'b0;

    // Reset during GNT_D before memory answers, with a ready arriving in the
    // reset cycle.
    do_reset();
    lat_cfg = 10;
    set_client(1, 1'b1, 1'b0, 28'h0000200, 128'd0, 1'b0);
    for (int t = 0; t < 3; t++) tick();
    rst_n = 1'b0;
    force_rdy = 1'b1;
    for (int k = 0; k < 2; k++) c_act[k][1] = 1'b0;
    tick();
    force_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("m%0d.rst_mem_read", k), m_rd[k], 1'b0);
      check_val($sformatf("m%0d.rst_d_gcnt", k), d_gc[k], 0);
      check_val($sformatf("m%0d.rst_no_dready", k), n_drdy[k], 0);
    end
    rst_n = 1'b1;
    tick();

    // Randomized traffic with random latencies, spurious readies and resets.
    do_reset();
    rand_en = 1'b1; spur_en = 1'b1; lat_rand = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
